dbus_data_mem: RTL and testbench

- Single-port 32-bit word-addressed data memory acting as the CPU data-bus slave.
- Uses a Wishbone-classic-style request/acknowledge handshake (cyc/stb/we/sel, done).
- Provides byte-lane writes and registered reads.
- Sits between the rv_cpu data bus and on-chip RAM. The bench may preload contents hierarchically through the storage array.

---
 rtl/dbus_data_mem.sv | 126 ++++++++++++
 tb/tb_dbus_data_mem.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_data_mem.sv
// -----------------------------------------------------------------------------
// dbus_data_mem
//   Single-port 32-bit word-addressed data memory serving as the CPU data-bus
//   slave. Classic cyc/stb request, one-cycle done acknowledge, byte-lane
//   writes and registered full-word reads.
//
//   Parameters:
//     ADDR_W      word-address width, depth = 2**ADDR_W words
//     WAIT_STATES extra cycles between request acceptance and the operation
//                 (0..15)
//     INIT_FILE   hex image name (informational)
//
//   Ports:
//     clk         clock, rising edge
//     rst_ni      asynchronous active-low reset
//     addr        word address
//     wr          1 = write, 0 = read
//     dbus_cyc_o  bus cycle active (from CPU)
//     dbus_stb_o  request strobe (from CPU)
//     sel         byte-lane enables, sel[i] covers wdata[8i+7:8i]
//     wdata       write data
//     rdata       registered read data, held until the next read
//     done        one-cycle acknowledge per accepted request
// -----------------------------------------------------------------------------
module dbus_data_mem #(
  parameter int ADDR_W      = 7,
  parameter int WAIT_STATES = 0,
  parameter     INIT_FILE   = "dmem.hex"
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic              dbus_cyc_o,
  input  logic              dbus_stb_o,
  input  logic [3:0]        sel,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;

  // With no wait states the operation happens on the acceptance edge itself.
  localparam bit         NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WS_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  // Storage is deliberately outside the reset domain so preloaded contents
  // survive reset.
  logic [31:0] mem [DEPTH];

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic       req;
  logic       do_op;

  always_comb begin
    req   = dbus_cyc_o & dbus_stb_o;
    do_op = 1'b0;
    // rst_ni gating keeps a zero-wait write from landing while reset is held.
    if (rst_ni) begin
      if (state_reg == IDLE)
        do_op = req & NO_WAIT;
      else if (state_reg == WAIT)
        do_op = (cnt_reg == 4'd0);
    end
  end

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    if (do_op && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i])
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      done      <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      done <= 1'b0;
      // Reads return the whole word; the CPU picks lanes and sign-extends.
      if (do_op && !wr)
        rdata <= mem[addr];
      case (state_reg)
        IDLE: begin
          if (req) begin
            if (NO_WAIT) begin
              state_reg <= ACK;
              done      <= 1'b1;
            end else begin
              cnt_reg   <= WS_LOAD;
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= ACK;
            done      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ACK: begin
          // Never accept here: a held request is picked up next IDLE edge.
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_data_mem.sv
module tb_dbus_data_mem;

  localparam int AW = 7;
  localparam int DEPTH = 128;

  logic          clk;
  logic          rst_ni;
  logic [AW-1:0] addr;
  logic          wr;
  logic [3:0]    sel;
  logic [31:0]   wdata;
  logic          cyc0, stb0, cyc2, stb2;
  logic [31:0]   rdata0, rdata2;
  logic          done0, done2;

  int total = 0;
  int bad   = 0;

  // Reference contents per instance: index 0 -> zero-wait, 1 -> two-wait.
  logic [31:0] model [2][DEPTH];
  logic [31:0] last_rd [2];

  dbus_data_mem #(.ADDR_W(AW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_ni(rst_ni), .addr(addr), .wr(wr),
    .dbus_cyc_o(cyc0), .dbus_stb_o(stb0), .sel(sel), .wdata(wdata),
    .rdata(rdata0), .done(done0)
  );

  dbus_data_mem #(.ADDR_W(AW), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst_ni(rst_ni), .addr(addr), .wr(wr),
    .dbus_cyc_o(cyc2), .dbus_stb_o(stb2), .sel(sel), .wdata(wdata),
    .rdata(rdata2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic cur_done(input int d);
    return (d == 0) ? done0 : done2;
  endfunction

  function automatic logic [31:0] cur_rdata(input int d);
    return (d == 0) ? rdata0 : rdata2;
  endfunction

  task automatic set_req(input int d, input logic v);
    if (d == 0) begin cyc0 = v; stb0 = v; end
    else        begin cyc2 = v; stb2 = v; end
  endtask

  // One full bus transaction; called just after a rising edge.
  task automatic bus_op(input int d, input logic [AW-1:0] a, input logic w,
                        input logic [3:0] s, input logic [31:0] wd);
    int   n;
    bit   seen;
    int   ws;
    logic [31:0] prev;
    ws   = (d == 0) ? 0 : 2;
    prev = cur_rdata(d);
    addr = a; wr = w; sel = s; wdata = wd;
    set_req(d, 1'b1);
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (cur_done(d)) seen = 1;
    end
    set_req(d, 1'b0);
    chk("latency", 32'(n), 32'(ws + 1));
    if (w) begin
      model[d][a] = merge(model[d][a], wd, s);
      chk("wr_keeps_rdata", cur_rdata(d), prev);
    end else begin
      last_rd[d] = model[d][a];
      chk("rd_data", cur_rdata(d), model[d][a]);
    end
    $display("dut%0d %s a=%02h sel=%b wd=%h rd=%h lat=%0d", (d == 0) ? 0 : 2,
             w ? "WR" : "RD", a, s, wd, cur_rdata(d), n);
    @(posedge clk); #1;
    chk("done_fall", 32'(cur_done(d)), 32'd0);
  endtask

  initial begin : main
    logic [31:0] v;
    logic [31:0] prev_word;
    bit          saw_done;
    int          d;
    logic [AW-1:0] a;

    rst_ni = 1'b0;
    cyc0 = 0; stb0 = 0; cyc2 = 0; stb2 = 0;
    addr = '0; wr = 0; sel = '0; wdata = '0;

    // Random preload of both arrays, with the known word at address 8.
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      dut0.mem[i] = v; model[0][i] = v;
      v = $urandom;
      dut2.mem[i] = v; model[1][i] = v;
    end
    dut0.mem[8] = 32'h12345678; model[0][8] = 32'h12345678;
    dut2.mem[8] = 32'h12345678; model[1][8] = 32'h12345678;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;

    #12;
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_done2", 32'(done2), 32'd0);
    chk("rst_rdata2", rdata2, 32'd0);
    #4 rst_ni = 1'b1;
    @(posedge clk); #1;

    // Preloaded word survives reset; zero-wait read timing.
    bus_op(0, 7'd8, 1'b0, 4'b1111, 32'h0);
    chk("preload_rd", rdata0, 32'h12345678);

    // Single-lane write, then a no-lane write.
    bus_op(0, 7'd8, 1'b1, 4'b0010, 32'hAABBCCDD);
    bus_op(0, 7'd8, 1'b0, 4'b1111, 32'h0);
    chk("lane1_rd", rdata0, 32'h1234CC78);
    bus_op(0, 7'd8, 1'b1, 4'b0000, 32'hFFFFFFFF);
    bus_op(0, 7'd8, 1'b0, 4'b1111, 32'h0);
    chk("sel0_rd", rdata0, 32'h1234CC78);

    // Address extremes, no aliasing.
    bus_op(0, 7'h7F, 1'b1, 4'b1111, 32'hDEADBEEF);
    bus_op(0, 7'h00, 1'b1, 4'b1111, 32'h00000001);
    bus_op(0, 7'h7F, 1'b0, 4'b1111, 32'h0);
    chk("top_rd", rdata0, 32'hDEADBEEF);
    bus_op(0, 7'h00, 1'b0, 4'b1111, 32'h0);
    chk("bot_rd", rdata0, 32'h00000001);

    // Two wait states: read then write-read.
    bus_op(1, 7'd8, 1'b0, 4'b1111, 32'h0);
    bus_op(1, 7'd5, 1'b1, 4'b1111, 32'hCAFEF00D);
    bus_op(1, 7'd5, 1'b0, 4'b1111, 32'h0);

    // Reset while a write is waiting: no write, no done.
    prev_word = model[1][5];
    addr = 7'd5; wr = 1'b1; sel = 4'b1111; wdata = 32'h0BADC0DE;
    set_req(1, 1'b1);
    @(posedge clk); #1;               // accepted, now waiting
    rst_ni = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (done2) saw_done = 1;
    end
    set_req(1, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done2) saw_done = 1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    chk("abort_rdata_rst", rdata2, 32'd0);
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    bus_op(1, 7'd5, 1'b0, 4'b1111, 32'h0);
    chk("abort_no_write", rdata2, prev_word);

    // Strobe without cycle (and cycle without strobe) is ignored.
    prev_word = rdata0;
    addr = 7'd9; wr = 1'b0; sel = 4'b1111;
    stb0 = 1'b1; cyc0 = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (done0) saw_done = 1; end
    stb0 = 1'b0; cyc0 = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (done0) saw_done = 1; end
    cyc0 = 1'b0;
    chk("partial_req_ignored", 32'(saw_done), 32'd0);
    chk("partial_req_rdata", rdata0, prev_word);

    // Held request: done 1,0,1,0 with a fresh read on the second pulse.
    addr = 7'd20; wr = 1'b0; sel = 4'b0001;
    set_req(0, 1'b1);
    @(posedge clk); #1;
    chk("held_done_c1", 32'(done0), 32'd1);
    chk("held_rd_c1", rdata0, model[0][20]);
    v = ~model[0][20];
    dut0.mem[20] = v; model[0][20] = v;
    @(posedge clk); #1;
    chk("held_done_c2", 32'(done0), 32'd0);
    @(posedge clk); #1;
    chk("held_done_c3", 32'(done0), 32'd1);
    chk("held_rd_c3", rdata0, v);
    @(posedge clk); #1;
    chk("held_done_c4", 32'(done0), 32'd0);
    set_req(0, 1'b0);
    $display("dut0 HELD a=14 rd=%h", rdata0);
    @(posedge clk); #1;

    // Randomized traffic on both instances.
    for (int k = 0; k < 60; k++) begin
      d = $urandom_range(0, 1);
      a = AW'($urandom_range(0, DEPTH - 1));
      if (k % 7 == 0) a = (k % 2 == 0) ? 7'h00 : 7'h7F;
      bus_op(d, a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end
    // Final sweep reading back a few words per instance.
    for (int k = 0; k < 16; k++) begin
      bus_op(k % 2, AW'(k * 8 + 3), 1'b0, 4'b1111, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
